// File: rtl/run_det_pkg.sv
// Shared constants for the run detector: FSM state width and encodings.
package run_det_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] S_IDLE = 2'd0;  // no sample since reset
    localparam logic [STATE_W-1:0] S_RUN  = 2'd1;  // counting a run
    localparam logic [STATE_W-1:0] S_HIT  = 2'd2;  // run qualified

endpackage

// File: rtl/sat_counter.sv
// Up-counter with enable and synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clock_i,
    input  logic         resetn_i,
    input  logic         en_i,
    input  logic         clear_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    // Next count: clear beats increment; increment stops at all-ones.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/run_detector.sv
// Detects RUN_LEN consecutive identical samples of w, with per-polarity enable,
// optional overlapping detection and a saturating hit counter.
module run_detector
    import run_det_pkg::*;
#(
    parameter int unsigned RUN_LEN = 4,
    parameter logic [1:0]  MODE    = 2'b11,
    parameter bit          OVERLAP = 1'b1,
    parameter int unsigned CNT_W   = 8,
    localparam int unsigned RW     = $clog2(RUN_LEN + 1)
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               en,
    input  logic               w,
    input  logic               clear,
    output logic               z,
    output logic               z_val,
    output logic [RW-1:0]      run_len_q,
    output logic [CNT_W-1:0]   det_count,
    output logic [STATE_W-1:0] state_q
);

    localparam logic [RW-1:0] RunMax = RW'(RUN_LEN);
    localparam logic [RW-1:0] RunOne = RW'(1);

    logic [STATE_W-1:0] state_d;
    logic [RW-1:0]      run_len_d;
    logic [RW-1:0]      run_inc;
    logic               z_val_q, z_val_d;
    logic               hit_inc;

    // Next-state, run length and run polarity.
    always_comb begin
        state_d   = state_q;
        run_len_d = run_len_q;
        z_val_d   = z_val_q;
        run_inc   = run_len_q + RunOne;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    z_val_d   = w;
                    run_len_d = RunOne;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (en) begin
                    if (w == z_val_q) begin
                        // A disabled polarity parks here at RunMax.
                        if (run_len_q != RunMax) begin
                            run_len_d = run_inc;
                        end
                        if ((run_inc == RunMax) && MODE[z_val_q]) begin
                            state_d = S_HIT;
                        end
                    end else begin
                        z_val_d   = w;
                        run_len_d = RunOne;
                    end
                end
            end
            S_HIT: begin
                if (en) begin
                    if (w == z_val_q) begin
                        // Non-overlapping: the matching bit opens a fresh run.
                        if (!OVERLAP) begin
                            run_len_d = RunOne;
                            state_d   = S_RUN;
                        end
                    end else begin
                        z_val_d   = w;
                        run_len_d = RunOne;
                        state_d   = S_RUN;
                    end
                end
            end
            default: begin
                // Unreachable encoding: recover regardless of en.
                state_d   = S_IDLE;
                run_len_d = '0;
                z_val_d   = 1'b0;
            end
        endcase
    end

    // FSM, run length and polarity registers; reset discards any run in progress.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            run_len_q <= '0;
            z_val_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_len_q <= run_len_d;
            z_val_q   <= z_val_d;
        end
    end

    assign hit_inc = en && (state_d == S_HIT);
    assign z       = (state_q == S_HIT);
    assign z_val   = z_val_q;

    sat_counter #(
        .W (CNT_W)
    ) u_det_count (
        .clock_i  (clock),
        .resetn_i (resetn),
        .en_i     (hit_inc),
        .clear_i  (clear),
        .count_o  (det_count)
    );

endmodule

// File: tb/tb_run_detector.sv
// Scoreboard bench for run_detector: four configurations share one stimulus stream,
// expectations are queued per step and compared one cycle later.
module tb_run_detector;

    localparam int unsigned SZ   = 0;
    localparam int unsigned SZV  = 1;
    localparam int unsigned SRUN = 2;
    localparam int unsigned SCNT = 3;
    localparam int unsigned SST  = 4;

    typedef struct {
        string       tag;
        int unsigned dut;
        int unsigned sig;
        int unsigned exp;
    } exp_t;

    logic clock;
    logic resetn;
    logic en;
    logic w;
    logic clear;

    logic       z_o     [4];
    logic       zv_o    [4];
    logic [2:0] run_o   [4];
    logic [1:0] st_o    [4];
    logic [7:0] cnt_o   [3];
    logic [1:0] cnt3_o;

    exp_t sb_q[$];
    int   checks;
    int   failures;

    // dut 0: defaults
    run_detector u_dut0 (
        .clock(clock), .resetn(resetn), .en(en), .w(w), .clear(clear),
        .z(z_o[0]), .z_val(zv_o[0]), .run_len_q(run_o[0]), .det_count(cnt_o[0]),
        .state_q(st_o[0])
    );

    // dut 1: non-overlapping
    run_detector #(.OVERLAP(1'b0)) u_dut1 (
        .clock(clock), .resetn(resetn), .en(en), .w(w), .clear(clear),
        .z(z_o[1]), .z_val(zv_o[1]), .run_len_q(run_o[1]), .det_count(cnt_o[1]),
        .state_q(st_o[1])
    );

    // dut 2: ones only
    run_detector #(.MODE(2'b10)) u_dut2 (
        .clock(clock), .resetn(resetn), .en(en), .w(w), .clear(clear),
        .z(z_o[2]), .z_val(zv_o[2]), .run_len_q(run_o[2]), .det_count(cnt_o[2]),
        .state_q(st_o[2])
    );

    // dut 3: 2-bit hit counter
    run_detector #(.CNT_W(2)) u_dut3 (
        .clock(clock), .resetn(resetn), .en(en), .w(w), .clear(clear),
        .z(z_o[3]), .z_val(zv_o[3]), .run_len_q(run_o[3]), .det_count(cnt3_o),
        .state_q(st_o[3])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned observe(input int unsigned d, input int unsigned s);
        case (s)
            SZ:      return int'(z_o[d]);
            SZV:     return int'(zv_o[d]);
            SRUN:    return int'(run_o[d]);
            SST:     return int'(st_o[d]);
            default: return (d == 3) ? int'(cnt3_o) : int'(cnt_o[d]);
        endcase
    endfunction

    task automatic push(input string tag, input int unsigned d, input int unsigned s,
                        input int unsigned e);
        exp_t x;
        x.tag = tag;
        x.dut = d;
        x.sig = s;
        x.exp = e;
        sb_q.push_back(x);
    endtask

    // Drive one sample, clock it, then drain the scoreboard against the DUT outputs.
    task automatic step(input logic rst_v, input logic en_v, input logic w_v, input logic clr_v);
        exp_t x;
        @(negedge clock);
        resetn = rst_v;
        en     = en_v;
        w      = w_v;
        clear  = clr_v;
        @(posedge clock);
        #1;
        while (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            check_eq(x.tag, observe(x.dut, x.sig), x.exp);
        end
    endtask

    initial begin
        int unsigned zexp1 [5] = '{0, 0, 0, 1, 1};
        int unsigned rexp1 [5] = '{1, 2, 3, 4, 4};
        int unsigned w2    [8] = '{1, 1, 1, 0, 1, 1, 1, 1};
        int unsigned rexp2 [8] = '{1, 2, 3, 1, 1, 2, 3, 4};
        int unsigned zexp3 [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        int unsigned rexp3 [8] = '{1, 2, 3, 4, 1, 2, 3, 4};
        int unsigned en5   [6] = '{1, 0, 1, 0, 1, 1};
        int unsigned w5    [6] = '{0, 1, 0, 1, 0, 0};
        int unsigned zexp5 [6] = '{0, 0, 0, 0, 0, 1};
        int unsigned rexp5 [6] = '{1, 1, 2, 2, 3, 4};

        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        en       = 1'b0;
        w        = 1'b0;
        clear    = 1'b0;

        // Reset state of every instance
        for (int d = 0; d < 4; d++) begin
            push($sformatf("rst_z_d%0d", d), d, SZ, 0);
            push($sformatf("rst_zval_d%0d", d), d, SZV, 0);
            push($sformatf("rst_run_d%0d", d), d, SRUN, 0);
            push($sformatf("rst_cnt_d%0d", d), d, SCNT, 0);
            push($sformatf("rst_state_d%0d", d), d, SST, 0);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0);

        // 1: five zeros, overlapping
        for (int i = 0; i < 5; i++) begin
            push($sformatf("t1_z_%0d", i), 0, SZ, zexp1[i]);
            push($sformatf("t1_run_%0d", i), 0, SRUN, rexp1[i]);
            if (i == 4) begin
                push("t1_cnt", 0, SCNT, 2);
                push("t1_state", 0, SST, 2);
            end
            step(1'b1, 1'b1, 1'b0, 1'b0);
        end

        // 2: 1110 then 1111
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            push($sformatf("t2_z_%0d", i), 0, SZ, (i == 7) ? 1 : 0);
            push($sformatf("t2_run_%0d", i), 0, SRUN, rexp2[i]);
            if (i == 7) push("t2_zval", 0, SZV, 1);
            step(1'b1, 1'b1, w2[i][0], 1'b0);
        end

        // 3: non-overlapping, eight ones
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            push($sformatf("t3_z_%0d", i), 1, SZ, zexp3[i]);
            push($sformatf("t3_run_%0d", i), 1, SRUN, rexp3[i]);
            if (i == 7) push("t3_cnt", 1, SCNT, 2);
            step(1'b1, 1'b1, 1'b1, 1'b0);
        end

        // 4: zeros disabled, eight zeros then four ones
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            push($sformatf("t4_z_%0d", i), 2, SZ, (i == 11) ? 1 : 0);
            push($sformatf("t4_run_%0d", i), 2, SRUN, (i < 8) ? ((i < 3) ? i + 1 : 4) : i - 7);
            if (i < 8) push($sformatf("t4_state_%0d", i), 2, SST, 1);
            if (i == 11) push("t4_cnt", 2, SCNT, 1);
            step(1'b1, 1'b1, (i >= 8), 1'b0);
        end

        // 5: en gating, then reset in the middle of a hit run
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            push($sformatf("t5_z_%0d", i), 0, SZ, zexp5[i]);
            push($sformatf("t5_run_%0d", i), 0, SRUN, rexp5[i]);
            step(1'b1, en5[i][0], w5[i][0], 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            push($sformatf("t5_zhold_%0d", i), 0, SZ, 1);
            step(1'b1, 1'b1, 1'b0, 1'b0);
        end
        push("t5_rst_z", 0, SZ, 0);
        push("t5_rst_state", 0, SST, 0);
        push("t5_rst_run", 0, SRUN, 0);
        push("t5_rst_cnt", 0, SCNT, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        push("t5_post_z", 0, SZ, 0);
        push("t5_post_state", 0, SST, 1);
        push("t5_post_run", 0, SRUN, 1);
        step(1'b1, 1'b1, 1'b0, 1'b0);

        // 6: 2-bit counter saturation and clear priority
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            push($sformatf("t6_cnt_%0d", i), 3, SCNT, (i < 3) ? 0 : ((i - 2 > 3) ? 3 : i - 2));
            push($sformatf("t6_z_%0d", i), 3, SZ, (i >= 3) ? 1 : 0);
            step(1'b1, 1'b1, 1'b0, 1'b0);
        end
        push("t6_clr_cnt", 3, SCNT, 0);
        push("t6_clr_z", 3, SZ, 1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        push("t6_after_cnt", 3, SCNT, 1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        push("t6_clr_noen_cnt", 3, SCNT, 0);
        push("t6_clr_noen_z", 3, SZ, 1);
        step(1'b1, 1'b0, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
